// File: rtl/block_packer_pkg.sv
// Shared definitions for the cipher input gearbox: type tags and parameter checks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package block_packer_pkg;

  // Type tags carried alongside each word and each assembled block.
  localparam int TYPE_KEY = 0;
  localparam int TYPE_ENC = 1;
  localparam int TYPE_DEC = 2;

  // Legal geometry: whole number of beats per block, at least two beats,
  // and a power-of-two FIFO depth so the pointers wrap for free.
  function automatic bit cfg_ok(input int in_w, input int blk_w, input int depth);
    return (in_w > 0) && (blk_w % in_w == 0) && (blk_w / in_w >= 2) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/block_packer_if.sv
// Word-in / block-out stream bundle for the cipher input gearbox.
// Latency: n/a (wires only).
// Backpressure: rin toward the word source, rout from the block consumer.
// Ports: vin/tin/din/rin input word handshake, flush drop-partial request,
//        vout/tout/dout/rout head block handshake, err type-change pulse,
//        level FIFO occupancy. master = stream driver, slave = packer.
interface block_packer_if #(
  parameter int IN_W   = 32,
  parameter int BLK_W  = 128,
  parameter int TYPE_W = 2,
  parameter int DEPTH  = 2
);
  logic                     vin;
  logic [TYPE_W-1:0]        tin;
  logic [IN_W-1:0]          din;
  logic                     rin;
  logic                     flush;
  logic                     vout;
  logic [TYPE_W-1:0]        tout;
  logic [BLK_W-1:0]         dout;
  logic                     rout;
  logic                     err;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output vin, tin, din, flush, rout,
    input  rin, vout, tout, dout, err, level
  );

  modport slave (
    input  vin, tin, din, flush, rout,
    output rin, vout, tout, dout, err, level
  );
endinterface

// File: rtl/block_packer_fifo.sv
// Generic DEPTH-entry register FIFO with occupancy count; head is combinational.
// Latency: pushed entry visible at the head the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata, full, empty, level.
module block_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // At full, the slot being written is the one being read out this cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem[rd_ptr];
  assign level = cnt_q;

endmodule

// File: rtl/block_packer.sv
// Cipher input gearbox: packs IN_W-bit tagged words MSB-first into BLK_W-bit blocks.
// Latency: block at the FIFO head the cycle after its final beat is accepted.
// Backpressure: only the final beat of a block stalls, and only while the FIFO is full.
// Ports: clk, rst (sync, active-high), bus (block_packer_if.slave): word input
//        handshake, flush, head block handshake, err pulse, FIFO level.
module block_packer
  import block_packer_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int BLK_W  = 128,
  parameter int TYPE_W = 2,
  parameter int DEPTH  = 2
) (
  input  logic           clk,
  input  logic           rst,
  block_packer_if.slave  bus
);
  localparam int N  = BLK_W / IN_W;
  localparam int CW = $clog2(N);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [0:0] FILL_IDLE = 1'b0;
  localparam logic [0:0] FILL_BUSY = 1'b1;

  if (!cfg_ok(IN_W, BLK_W, DEPTH)) begin : g_bad_cfg
    $error("block_packer: BLK_W must be a multiple (>=2) of IN_W and DEPTH a power of 2");
  end

  logic [0:0]              state;
  logic [CW-1:0]           cnt;
  logic [BLK_W-1:0]        asm_q;
  logic [TYPE_W-1:0]       blk_type;
  logic                    err_q;
  logic                    full;
  logic                    empty;
  logic                    accept;
  logic                    type_chg;
  logic                    push;
  logic                    pop;
  logic [BLK_W+TYPE_W-1:0] push_dat;
  logic [BLK_W+TYPE_W-1:0] head_dat;
  logic [LW-1:0]           fifo_level;

  // Registered terms only, so rin never depends on rout or vin.
  assign bus.rin  = (cnt != LAST) || !full;
  assign accept   = bus.vin && bus.rin;
  assign type_chg = (state == FILL_BUSY) && (bus.tin != blk_type);
  assign push     = accept && !bus.flush && !type_chg && (cnt == LAST);
  // Words shift in at the bottom, so after N beats beat 0 sits at the MSB end.
  assign push_dat = {blk_type, asm_q[BLK_W-IN_W-1:0], bus.din};
  assign pop      = !empty && bus.rout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL_IDLE;
      cnt      <= '0;
      asm_q    <= '0;
      blk_type <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.flush) begin
        state <= FILL_IDLE;
        cnt   <= '0;
      end else if (accept) begin
        asm_q <= {asm_q[BLK_W-IN_W-1:0], bus.din};
        if (type_chg) begin
          // Drop the partial block; this beat restarts as beat 0.
          err_q    <= 1'b1;
          blk_type <= bus.tin;
          cnt      <= CW'(1);
          state    <= FILL_BUSY;
        end else if (cnt == LAST) begin
          cnt   <= '0;
          state <= FILL_IDLE;
        end else begin
          if (state == FILL_IDLE) blk_type <= bus.tin;
          cnt   <= cnt + 1'b1;
          state <= FILL_BUSY;
        end
      end
    end
  end

  block_fifo #(
    .WIDTH (BLK_W + TYPE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_dat),
    .pop   (pop),
    .rdata (head_dat),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign bus.vout  = !empty;
  assign bus.tout  = head_dat[BLK_W+TYPE_W-1:BLK_W];
  assign bus.dout  = head_dat[BLK_W-1:0];
  assign bus.err   = err_q;
  assign bus.level = fifo_level;

endmodule
